request_scheduler: RTL and testbench

REQUEST_SCHEDULER -- requirements
Module: request_scheduler

---
 rtl/request_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_request_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_scheduler.sv
// Single-car elevator request scheduler: latches car/hall requests, sweeps the
// car in its current direction, and holds the door open for a fixed number of cycles per stop.
module request_scheduler #(
  parameter int FLOORS      = 4,
  parameter int FW          = $clog2(FLOORS),
  parameter int DOOR_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] dest_req,
  input  logic [FLOORS-1:0] up_call,
  input  logic [FLOORS-1:0] down_call,
  input  logic [FW-1:0]     cur_floor,
  input  logic              at_floor,
  output logic              move_up,
  output logic              move_down,
  output logic              door_open,
  output logic [FLOORS-1:0] dest_pend,
  output logic [FLOORS-1:0] up_pend,
  output logic [FLOORS-1:0] down_pend,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_DOOR = 2'b11
  } state_t;

  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);

  // No hall call exists above the top floor or below the ground floor.
  localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  state_t        st, st_nxt;
  logic          ldir, ldir_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  int   cur_i;
  logic cur_valid;
  logic above, below;
  logic here_any, here_dest, here_up_raw, here_dn_raw;
  logic here_up, here_dn;
  logic [FLOORS-1:0] clr_dest, clr_up, clr_dn;

  assign cur_i     = int'(cur_floor);
  assign cur_valid = (cur_i < FLOORS);

  // An out-of-range floor sees nothing here, above or below.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    above       = 1'b0;
    below       = 1'b0;
    here_dest   = 1'b0;
    here_up_raw = 1'b0;
    here_dn_raw = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      if (f > cur_i)
        above = above | dest_pend[f] | up_pend[f] | down_pend[f];
      if (cur_valid && (f < cur_i))
        below = below | dest_pend[f] | up_pend[f] | down_pend[f];
      if (f == cur_i) begin
        here_dest   = dest_pend[f];
        here_up_raw = up_pend[f];
        here_dn_raw = down_pend[f];
      end
    end
  end

  assign here_any = here_dest | here_up_raw | here_dn_raw;
  assign here_up  = here_dest | here_up_raw | (here_dn_raw & ~above);
  assign here_dn  = here_dest | here_dn_raw | (here_up_raw & ~below);

  // A hall call is only serviced when the car will leave in that direction.
  always_comb begin
    clr_dest = '0;
    clr_up   = '0;
    clr_dn   = '0;
    if (st == S_DOOR) begin
      for (int f = 0; f < FLOORS; f++) begin
        if (f == cur_i) begin
          clr_dest[f] = 1'b1;
          clr_up[f]   = ~ldir | ~below;
          clr_dn[f]   = ldir | ~above;
        end
      end
    end
  end

  // Clear is applied after set so a request at a serviced floor is absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_pend <= '0;
      up_pend   <= '0;
      down_pend <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      dest_pend <= (dest_pend | dest_req) & ~clr_dest;
      up_pend   <= (up_pend | (up_call & UP_MASK)) & ~clr_up;
      down_pend <= (down_pend | (down_call & DN_MASK)) & ~clr_dn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= S_IDLE;
      ldir <= 1'b0;
      cnt  <= '0;
    end else begin
      st   <= st_nxt;
      ldir <= ldir_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    ldir_nxt = ldir;
    cnt_nxt  = cnt;
    unique case (st)
      S_IDLE: begin
        if (here_any) begin
          st_nxt  = S_DOOR;
          cnt_nxt = DOOR_LOAD;
        end else if (above) begin
          st_nxt   = S_UP;
          ldir_nxt = 1'b0;
        end else if (below) begin
          st_nxt   = S_DOWN;
          ldir_nxt = 1'b1;
        end
      end
      S_UP: begin
        if (at_floor) begin
          if (here_up) begin
            st_nxt  = S_DOOR;
            cnt_nxt = DOOR_LOAD;
          end else if (!above) begin
            st_nxt = S_IDLE;
          end
        end
      end
      S_DOWN: begin
        if (at_floor) begin
          if (here_dn) begin
            st_nxt  = S_DOOR;
            cnt_nxt = DOOR_LOAD;
          end else if (!below) begin
            st_nxt = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        if (cnt == '0) begin
          // Keep sweeping upward if that was the last direction, otherwise prefer down.
          if (!ldir && above) begin
            st_nxt   = S_UP;
            ldir_nxt = 1'b0;
          end else if (below) begin
            st_nxt   = S_DOWN;
            ldir_nxt = 1'b1;
          end else if (above) begin
            st_nxt   = S_UP;
            ldir_nxt = 1'b0;
          end else begin
            st_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  assign state     = st;
  assign move_up   = (st == S_UP);
  assign move_down = (st == S_DOWN);
  assign door_open = (st == S_DOOR);

endmodule

// File: tb/tb_request_scheduler.sv
// Bench for request_scheduler: directed scenarios with literal expectations plus
// randomized traffic against a floor-list reference model compared every cycle.
module tb_request_scheduler;

  localparam int F = 4;
  localparam int D = 3;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [F-1:0] dest_req = '0, up_call = '0, down_call = '0;
  logic [1:0]   cur_floor = '0;
  logic         at_floor = 1'b0;
  logic         move_up, move_down, door_open;
  logic [F-1:0] dest_pend, up_pend, down_pend;
  logic [1:0]   state;

  request_scheduler #(.FLOORS(F), .DOOR_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .dest_req(dest_req), .up_call(up_call), .down_call(down_call),
    .cur_floor(cur_floor), .at_floor(at_floor),
    .move_up(move_up), .move_down(move_down), .door_open(door_open),
    .dest_pend(dest_pend), .up_pend(up_pend), .down_pend(down_pend),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-floor request lists and a sweep controller.
  int       m_state = M_IDLE;
  int       m_door_left = 0;
  bit       m_going_down = 1'b0;
  bit [F-1:0] m_dest = '0, m_up = '0, m_dn = '0;

  function automatic bit m_any(input int f);
    return m_dest[f] | m_up[f] | m_dn[f];
  endfunction

  function automatic bit m_above(input int c);
    for (int f = c + 1; f < F; f++) if (m_any(f)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_below(input int c);
    for (int f = 0; f < c; f++) if (m_any(f)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int c;
    bit ab, be, stop_up, stop_dn;
    bit [F-1:0] nd, nu, ndn;
    if (rst) begin
      m_state = M_IDLE; m_door_left = 0; m_going_down = 1'b0;
      m_dest = '0; m_up = '0; m_dn = '0;
    end else begin
      c  = int'(cur_floor);
      ab = m_above(c);
      be = m_below(c);
      stop_up = m_dest[c] | m_up[c] | (m_dn[c] & !ab);
      stop_dn = m_dest[c] | m_dn[c] | (m_up[c] & !be);
      nd  = m_dest | dest_req;
      nu  = m_up | (up_call & 4'b0111);
      ndn = m_dn | (down_call & 4'b1110);
      if (m_state == M_DOOR) begin
        nd[c] = 1'b0;
        if (!m_going_down || !be) nu[c] = 1'b0;
        if (m_going_down || !ab) ndn[c] = 1'b0;
      end
      case (m_state)
        M_IDLE:
          if (m_any(c)) begin m_state = M_DOOR; m_door_left = D; end
          else if (ab) begin m_state = M_UP; m_going_down = 1'b0; end
          else if (be) begin m_state = M_DOWN; m_going_down = 1'b1; end
        M_UP:
          if (at_floor) begin
            if (stop_up) begin m_state = M_DOOR; m_door_left = D; end
            else if (!ab) m_state = M_IDLE;
          end
        M_DOWN:
          if (at_floor) begin
            if (stop_dn) begin m_state = M_DOOR; m_door_left = D; end
            else if (!be) m_state = M_IDLE;
          end
        default: begin
          m_door_left--;
          if (m_door_left == 0) begin
            if (!m_going_down && ab) m_state = M_UP;
            else if (be) begin m_state = M_DOWN; m_going_down = 1'b1; end
            else if (ab) begin m_state = M_UP; m_going_down = 1'b0; end
            else m_state = M_IDLE;
          end
        end
      endcase
      m_dest = nd; m_up = nu; m_dn = ndn;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", state, m_state);
      check("move_up", move_up, m_state == M_UP);
      check("move_down", move_down, m_state == M_DOWN);
      check("door_open", door_open, m_state == M_DOOR);
      check("dest_pend", dest_pend, m_dest);
      check("up_pend", up_pend, m_up);
      check("down_pend", down_pend, m_dn);
    end
  end

  // Applies inputs for one rising edge; returns at the following falling edge.
  task automatic step(input logic [F-1:0] d, input logic [F-1:0] u, input logic [F-1:0] dn,
                      input logic af, input logic [1:0] cur);
    dest_req = d; up_call = u; down_call = dn; at_floor = af; cur_floor = cur;
    @(negedge clk);
    dest_req = '0; up_call = '0; down_call = '0; at_floor = 1'b0;
  endtask

  task automatic car_step(input logic [F-1:0] d, input logic [F-1:0] u, input logic [F-1:0] dn);
    logic af;
    logic [1:0] c;
    af = 1'b0;
    c  = cur_floor;
    if (move_up || move_down) begin
      if ($urandom_range(0, 2) == 0) begin
        af = 1'b1;
        if (move_up && c < 2'd3) c = c + 2'd1;
        else if (move_down && c > 2'd0) c = c - 2'd1;
      end
    end else if ($urandom_range(0, 9) == 0) begin
      af = 1'b1;
    end
    step(d, u, dn, af, c);
  endtask

  function automatic logic [F-1:0] rnd_bits();
    logic [F-1:0] r;
    for (int i = 0; i < F; i++) r[i] = ($urandom_range(0, 11) == 0);
    return r;
  endfunction

  task automatic settle(input string name);
    int i;
    i = 0;
    while (i < 400 && !(m_state == M_IDLE && m_dest == '0 && m_up == '0 && m_dn == '0)) begin
      car_step('0, '0, '0);
      i++;
    end
    check(name, (m_state == M_IDLE && m_dest == '0 && m_up == '0 && m_dn == '0), 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset_state", state, 2'b00);
    check("reset_door", door_open, 0);
    check("reset_pend", {dest_pend, up_pend, down_pend}, 0);

    // Ride from 0 to destination 2, passing floor 1.
    step(4'b0100, '0, '0, 1'b0, 2'd0);
    check("r33_dest_latched", dest_pend, 4'b0100);
    check("r33_still_idle", state, 2'b00);
    step('0, '0, '0, 1'b0, 2'd0);
    check("r33_move_up", move_up, 1);
    step('0, '0, '0, 1'b1, 2'd1);
    check("r33_pass_floor1", state, 2'b01);
    step('0, '0, '0, 1'b1, 2'd2);
    n = door_open;
    step('0, '0, '0, 1'b0, 2'd2);
    n += door_open;
    check("r33_dest_cleared", dest_pend, 4'b0000);
    repeat (2) begin step('0, '0, '0, 1'b0, 2'd2); n += door_open; end
    check("r33_door_len", n, D);
    check("r33_idle_after", state, 2'b00);

    // Hall up-call at the floor the idle car is parked at.
    step('0, '0, '0, 1'b0, 2'd1);
    step('0, 4'b0010, '0, 1'b0, 2'd1);
    check("r34_up_latched", up_pend, 4'b0010);
    step('0, '0, '0, 1'b0, 2'd1);
    check("r34_door", door_open, 1);
    n = 1;
    repeat (3) begin step('0, '0, '0, 1'b0, 2'd1); n += door_open; end
    check("r34_door_len", n, D);
    check("r34_up_cleared", up_pend, 4'b0000);

    // Down-call at 2 is skipped on the way up to 3 and served on the way back.
    step('0, '0, '0, 1'b0, 2'd0);
    step(4'b1000, '0, 4'b0100, 1'b0, 2'd0);
    step('0, '0, '0, 1'b0, 2'd0);
    check("r35_up", state, 2'b01);
    step('0, '0, '0, 1'b1, 2'd1);
    step('0, '0, '0, 1'b1, 2'd2);
    check("r35_no_stop_2", state, 2'b01);
    step('0, '0, '0, 1'b1, 2'd3);
    check("r35_stop_3", state, 2'b11);
    repeat (3) step('0, '0, '0, 1'b0, 2'd3);
    check("r35_then_down", state, 2'b10);
    step('0, '0, '0, 1'b1, 2'd2);
    check("r35_stop_2", state, 2'b11);
    step('0, '0, '0, 1'b0, 2'd2);
    check("r35_down_cleared", down_pend, 4'b0000);
    repeat (2) step('0, '0, '0, 1'b0, 2'd2);
    check("r35_idle", state, 2'b00);

    // Hall calls that cannot exist are dropped.
    step('0, 4'b1000, 4'b0001, 1'b0, 2'd2);
    check("r36_up_ignored", up_pend, 4'b0000);
    check("r36_down_ignored", down_pend, 4'b0000);
    step('0, '0, '0, 1'b0, 2'd2);
    check("r36_idle", state, 2'b00);

    // Requests during the door at floor 2 while heading up with a call above.
    step('0, '0, '0, 1'b0, 2'd0);
    step(4'b1100, '0, '0, 1'b0, 2'd0);
    step('0, '0, '0, 1'b0, 2'd0);
    step('0, '0, '0, 1'b1, 2'd1);
    step('0, '0, '0, 1'b1, 2'd2);
    check("r38_door_2", state, 2'b11);
    step(4'b0100, '0, 4'b0100, 1'b0, 2'd2);
    check("r38_dest_absorbed", dest_pend, 4'b1000);
    check("r38_down_kept", down_pend, 4'b0100);
    settle("r38_settle");

    // Reset in the second door cycle.
    step('0, '0, '0, 1'b0, 2'd1);
    step(4'b0011, '0, '0, 1'b0, 2'd1);
    step('0, '0, '0, 1'b0, 2'd1);
    step('0, '0, '0, 1'b0, 2'd1);
    check("r37_door_c2", door_open, 1);
    check("r37_pend", dest_pend, 4'b0001);
    #2 rst = 1'b1;
    #1;
    check("r37_rst_state", state, 2'b00);
    check("r37_rst_outs", {move_up, move_down, door_open}, 3'b000);
    check("r37_rst_pend", {dest_pend, up_pend, down_pend}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 700; i++) begin
      if (i == 350) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      car_step(rnd_bits(), rnd_bits(), rnd_bits());
    end
    settle("random_settle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
